matmul_sequencer: RTL

Controller that runs one matrix-multiply job on matmul_calc_module. It takes a start command and dimensions, and fetches A rows, B rows and C bias elements from three 1-cycle-latency operand banks. It streams them into the calc unit by holding its start line, then waits for the calc unit's write-back and finish before releasing it. It sits between the register/control block and matmul_calc_module and reports busy, done, error and the overflow flags.

---
 rtl/matmul_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/matmul_sequencer.sv
// Job controller for matmul_calc_module: fetches A/B/C operands from 1-cycle banks,
// holds calc start through write-back, and reports busy/done/error/flags.
module matmul_sequencer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BUS_WIDTH      = 16,
  parameter int unsigned IDX_W          = 2 * $clog2(BUS_WIDTH / DATA_WIDTH) + 1,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [1:0]           n_dim_i,
  input  logic [1:0]           k_dim_i,
  input  logic [1:0]           m_dim_i,
  output logic                 rd_en_a_o,
  output logic [IDX_W-1:0]     rd_idx_a_o,
  input  logic [BUS_WIDTH-1:0] rd_data_a_i,
  output logic                 rd_en_b_o,
  output logic [IDX_W-1:0]     rd_idx_b_o,
  input  logic [BUS_WIDTH-1:0] rd_data_b_i,
  output logic                 rd_en_c_o,
  output logic [IDX_W-1:0]     rd_idx_c_o,
  input  logic [BUS_WIDTH-1:0] rd_data_c_i,
  output logic                 calc_start_o,
  output logic                 calc_mode_o,
  output logic [1:0]           calc_n_o,
  output logic [1:0]           calc_k_o,
  output logic [1:0]           calc_m_o,
  output logic [BUS_WIDTH-1:0] calc_a_o,
  output logic [BUS_WIDTH-1:0] calc_b_o,
  output logic [BUS_WIDTH-1:0] calc_c_o,
  input  logic                 calc_wr_en_i,
  input  logic                 calc_finish_i,
  input  logic [BUS_WIDTH-1:0] calc_flags_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [BUS_WIDTH-1:0] flags_o
);

  localparam int unsigned MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WR_W    = TO_W + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDone} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [WR_W-1:0]      wr_cnt_q, wr_cnt_d, wr_total;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 mode_q, mode_d;
  logic [1:0]           n_q, n_d, k_q, k_d, m_q, m_d;
  logic                 err_q, err_d;
  logic [BUS_WIDTH-1:0] flags_q, flags_d;
  logic                 rd_en_a_q, rd_en_a_d, rd_en_b_q, rd_en_b_d, rd_en_c_q, rd_en_c_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic                 calc_start_q, calc_start_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [IDX_W-1:0]     load_last, n_ext, m_ext;
  logic                 dims_ok, in_load;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_cnt_d = wr_cnt_q;
    to_cnt_d = to_cnt_q;
    mode_d   = mode_q;
    n_d      = n_q;
    k_d      = k_q;
    m_d      = m_q;
    err_d    = err_q;
    flags_d  = flags_q;

    // (n+1)*(m+1) always dominates n+1 and m+1, so it alone sets the load length.
    load_last = (IDX_W'(n_q) + 1'b1) * (IDX_W'(m_q) + 1'b1) - 1'b1;
    wr_total  = wr_cnt_q + WR_W'(calc_wr_en_i);
    dims_ok   = (32'(n_dim_i) <= MAX_DIM - 1) && (32'(k_dim_i) <= MAX_DIM - 1) &&
                (32'(m_dim_i) <= MAX_DIM - 1);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (dims_ok) begin
            mode_d   = mode_i;
            n_d      = n_dim_i;
            k_d      = k_dim_i;
            m_d      = m_dim_i;
            err_d    = 1'b0;
            cnt_d    = '0;
            wr_cnt_d = '0;
            to_cnt_d = '0;
            state_d  = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (cnt_q == load_last) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        wr_cnt_d = wr_total;
        if (calc_finish_i) begin
          flags_d = calc_flags_i;
          if (wr_total != WR_W'(MAX_DIM * MAX_DIM)) err_d = 1'b1;
          state_d = StDone;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    n_ext        = IDX_W'(n_d);
    m_ext        = IDX_W'(m_d);
    in_load      = (state_d == StLoad);
    rd_en_a_d    = in_load && (cnt_d <= n_ext);
    rd_en_b_d    = in_load && (cnt_d <= m_ext);
    rd_en_c_d    = in_load;
    rd_idx_d     = in_load ? cnt_d : '0;
    calc_start_d = (in_load && (cnt_d != '0)) || (state_d == StWait);
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StDone);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wr_cnt_q     <= '0;
      to_cnt_q     <= '0;
      mode_q       <= 1'b0;
      n_q          <= '0;
      k_q          <= '0;
      m_q          <= '0;
      err_q        <= 1'b0;
      flags_q      <= '0;
      rd_en_a_q    <= 1'b0;
      rd_en_b_q    <= 1'b0;
      rd_en_c_q    <= 1'b0;
      rd_idx_q     <= '0;
      calc_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      to_cnt_q     <= to_cnt_d;
      mode_q       <= mode_d;
      n_q          <= n_d;
      k_q          <= k_d;
      m_q          <= m_d;
      err_q        <= err_d;
      flags_q      <= flags_d;
      rd_en_a_q    <= rd_en_a_d;
      rd_en_b_q    <= rd_en_b_d;
      rd_en_c_q    <= rd_en_c_d;
      rd_idx_q     <= rd_idx_d;
      calc_start_q <= calc_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_en_a_o    = rd_en_a_q;
  assign rd_en_b_o    = rd_en_b_q;
  assign rd_en_c_o    = rd_en_c_q;
  assign rd_idx_a_o   = rd_idx_q;
  assign rd_idx_b_o   = rd_idx_q;
  assign rd_idx_c_o   = rd_idx_q;
  assign calc_start_o = calc_start_q;
  assign calc_mode_o  = mode_q;
  assign calc_n_o     = n_q;
  assign calc_k_o     = k_q;
  assign calc_m_o     = m_q;
  assign calc_a_o     = rd_data_a_i;
  assign calc_b_o     = rd_data_b_i;
  assign calc_c_o     = rd_data_c_i;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign flags_o      = flags_q;

endmodule
